ecg_adc_spi_sampler_axis: RTL and testbench



---
 rtl/ecg_adc_spi_sampler_axis.sv | 113 +++++++++++
 tb/tb_ecg_adc_spi_sampler_axis.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ecg_adc_spi_sampler_axis.sv
// ecg_adc_spi_sampler_axis: paced MCP3202 SPI conversions delivered as signed samples on an AXI4-Stream master
module ecg_adc_spi_sampler_axis #(
    parameter int inout_width   = 16,
    parameter int adc_width     = 12,
    parameter int clk_div       = 50,
    parameter int sample_period = 200000,
    parameter int adc_channel   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [inout_width-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   spi_cs_n,
    output logic                   spi_sclk,
    output logic                   spi_mosi,
    input  logic                   spi_miso,
    output logic                   overrun
);
    localparam int CW = $clog2(sample_period);
    localparam int DW = $clog2(2 * clk_div + 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [DW-1:0]          r_div;
    logic [4:0]             r_bit;
    logic [adc_width-1:0]   r_shift;
    logic                   w_tick;
    logic                   w_half_end;
    logic                   w_bit_end;
    logic [inout_width-1:0] w_sample;

    assign w_tick     = r_cnt == CW'(sample_period - 1);
    assign w_half_end = r_div == DW'(clk_div - 1);
    assign w_bit_end  = r_div == DW'(2 * clk_div - 1);
    // Offset-binary to two's complement is an MSB flip; then left-justify into the output width.
    assign w_sample   = {~r_shift[adc_width-1], r_shift[adc_width-2:0], {(inout_width-adc_width){1'b0}}};

    // Command word: start, single-ended, channel select, MSB-first, then zeros.
    function automatic logic mosi_bit(input logic [4:0] b);
        return (b == 5'd0) || (b == 5'd1) || (b == 5'd3) || (b == 5'd2 && adc_channel != 0);
    endfunction

    // Free-running sample pacer; wraps on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end

    // SPI frame sequencer with registered SPI/AXIS outputs and the load/drop decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_div         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            spi_cs_n      <= 1'b1;
            spi_sclk      <= 1'b0;
            spi_mosi      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            case (r_state)
                IDLE: if (w_tick) begin
                    r_state  <= CS_SETUP;
                    spi_cs_n <= 1'b0;
                    r_div    <= '0;
                end
                CS_SETUP: if (w_half_end) begin
                    r_state  <= SHIFT;
                    r_div    <= '0;
                    r_bit    <= '0;
                    spi_mosi <= mosi_bit(5'd0);
                end else r_div <= r_div + 1'b1;
                SHIFT: begin
                    r_div <= r_div + 1'b1;
                    if (w_half_end) begin
                        spi_sclk <= 1'b1;
                        r_shift  <= {r_shift[adc_width-2:0], spi_miso};
                    end
                    if (w_bit_end) begin
                        r_div    <= '0;
                        spi_sclk <= 1'b0;
                        if (r_bit == 5'd16) begin
                            r_state  <= CS_HOLD;
                            spi_mosi <= 1'b0;
                        end else begin
                            r_bit    <= r_bit + 5'd1;
                            spi_mosi <= mosi_bit(r_bit + 5'd1);
                        end
                    end
                end
                CS_HOLD: if (w_half_end) begin
                    r_state  <= DONE;
                    spi_cs_n <= 1'b1;
                end else r_div <= r_div + 1'b1;
                DONE: begin
                    r_state <= IDLE;
                    if (!m_axis_tvalid || m_axis_tready) begin
                        m_axis_tdata  <= w_sample;
                        m_axis_tvalid <= 1'b1;
                    end else overrun <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecg_adc_spi_sampler_axis.sv
// tb_ecg_adc_spi_sampler_axis: scoreboard bench with a cycle-scheduled MCP3202 model for both channel settings
module tb_ecg_adc_spi_sampler_axis;
    localparam int CD    = 2;
    localparam int SP    = 200;
    localparam int DONE0 = SP - 1 + 36 * CD + 1;

    typedef struct packed {logic [15:0] d; int c;} ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy0 = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        mv = 1'b0;
    logic        tmo = 1'b0;
    logic        fin_req = 1'b0;
    logic        fin_done = 1'b0;
    logic [11:0] fcode [2];
    logic [11:0] stim_q [$];
    ent_t        exp_q [$];
    int          ov_q [$];

    always #5 clk = ~clk;

    function automatic logic [15:0] conv(input logic [11:0] c);
        int s;
        s = (int'(c) - 2048) * 16;
        return s[15:0];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        logic [15:0] tdata;
        logic        tvalid, cs_n, sclk, mosi, ovr;
        logic        miso = 1'b0;
        logic        p_cs = 1'b1;
        logic        p_sclk = 1'b0;
        logic [16:0] pat = '0;
        logic [11:0] fc;
        int          low = 0, edges = 0, nfall = 0, viol = 0, e = 0;

        ecg_adc_spi_sampler_axis #(
            .inout_width(16), .adc_width(12), .clk_div(CD), .sample_period(SP), .adc_channel(g)
        ) dut (
            .clk(clk), .rst_n(rst_n), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
            .m_axis_tready(g == 0 ? rdy0 : 1'b1), .spi_cs_n(cs_n), .spi_sclk(sclk),
            .spi_mosi(mosi), .spi_miso(miso), .overrun(ovr)
        );

        // Frame checker plus MCP3202 DOUT model driven during SCLK low phases.
        always @(negedge clk) begin
            if (!rst_n) begin
                low = 0; edges = 0; nfall = 0; viol = 0; pat = '0;
                p_cs = 1'b1; p_sclk = 1'b0; miso = 1'b0;
            end else begin
                if (cs_n && sclk) viol++;
                if (!cs_n) begin
                    if (p_cs) begin
                        chk($sformatf("cs_fall_cycle_ch%0d", g), cyc, 200 * (nfall + 1));
                        nfall++; low = 0; edges = 0; pat = '0;
                    end
                    low++;
                    if (sclk && !p_sclk) begin
                        edges++;
                        pat = {pat[15:0], mosi};
                    end
                    if (!sclk) begin
                        e = edges + 1;
                        fc = fcode[g];
                        miso = (e >= 6 && e <= 17) ? fc[17 - e] : 1'($urandom);
                    end
                end else if (!p_cs) begin
                    chk($sformatf("cs_low_len_ch%0d", g), low, 36 * CD);
                    chk($sformatf("sclk_edges_ch%0d", g), edges, 17);
                    chk($sformatf("mosi_word_ch%0d", g), pat, g ? 17'h1E000 : 17'h1A000);
                    chk($sformatf("sclk_idle_ch%0d", g), viol, 0);
                    viol = 0;
                end
                p_cs = cs_n;
                p_sclk = sclk;
            end
        end
    end

    // Reference model: frame schedule from the pacer rules, load/drop rule at each DONE.
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            mv = 1'b0;
            exp_q.delete();
            ov_q.delete();
        end else begin
            if (cyc % SP == SP - 1) begin
                fcode[0] = stim_q.size() > 0 ? stim_q.pop_front() : 12'($urandom);
                fcode[1] = 12'($urandom);
            end
            if (mv && rdy0) mv = 1'b0;
            if (cyc >= DONE0 && (cyc - DONE0) % SP == 0) begin
                if (!mv) begin
                    exp_q.push_back('{d: conv(fcode[0]), c: cyc + 1});
                    mv = 1'b1;
                end else ov_q.push_back(cyc + 1);
            end
            cyc++;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard heads every cycle.
    always @(negedge clk) begin
        logic exp_v, exp_o, e1;
        if (!rst_n) begin
            chk("rst_cs_n", u[0].cs_n, 1);
            chk("rst_sclk", u[0].sclk, 0);
            chk("rst_mosi", u[0].mosi, 0);
            chk("rst_tvalid", u[0].tvalid, 0);
            chk("rst_tdata", u[0].tdata, 0);
            chk("rst_overrun", u[0].ovr, 0);
        end else begin
            exp_v = exp_q.size() > 0 && exp_q[0].c <= cyc;
            chk("tvalid", u[0].tvalid, exp_v);
            if (exp_v) begin
                chk("tdata", u[0].tdata, exp_q[0].d);
                if (rdy0) void'(exp_q.pop_front());
            end
            exp_o = ov_q.size() > 0 && ov_q[0] == cyc;
            if (exp_o) void'(ov_q.pop_front());
            chk("overrun", u[0].ovr, exp_o);
            e1 = cyc >= DONE0 + 1 && (cyc - DONE0 - 1) % SP == 0;
            chk("tvalid_ch1", u[1].tvalid, e1);
            if (e1) chk("tdata_ch1", u[1].tdata, conv(fcode[1]));
            chk("overrun_ch1", u[1].ovr, 0);
        end
        if (fin_req && !fin_done) begin
            chk("pending_samples", exp_q.size(), 0);
            chk("pending_overruns", ov_q.size(), 0);
            chk("wait_timeout", tmo, 0);
            fin_done = 1'b1;
        end
    end

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc != n && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 5000) tmo = 1'b1;
    endtask

    initial begin
        stim_q.push_back(12'h800);
        stim_q.push_back(12'hFFF);
        stim_q.push_back(12'h000);
        stim_q.push_back(12'h123);
        stim_q.push_back(12'h900);
        stim_q.push_back(12'hA00);
        stim_q.push_back(12'($urandom));
        stim_q.push_back(12'($urandom));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(1000); rdy0 = 1'b0;
        wait_cyc(1300); rdy0 = 1'b1;
        wait_cyc(1400); rdy0 = 1'b0;
        wait_cyc(1672); rdy0 = 1'b1;
        wait_cyc(1673); rdy0 = 1'b0;
        wait_cyc(1830); rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy0 = 1'b1;
        for (int w = 0; w < 12; w++) begin
            wait_cyc(100 * (w + 1));
            rdy0 = $urandom_range(0, 2) != 0;
        end
        wait_cyc(1250); rdy0 = 1'b1;
        wait_cyc(1400);
        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
